// File: rtl/kgp_wb_pkg.sv
// Shared constants for the register-file write-back path: default widths and requester indices.
package kgp_wb_pkg;

   localparam int unsigned NUM_REQ_DEFAULT = 3;
   localparam int unsigned ADDR_W_DEFAULT  = 5;
   localparam int unsigned DATA_W_DEFAULT  = 32;

   localparam int unsigned REQ_ALU  = 0;
   localparam int unsigned REQ_MEM  = 1;
   localparam int unsigned REQ_LINK = 2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Write-back arbiter: one-hot grant from a request vector.
// ARB_ROUND_ROBIN_EN selects round-robin with an internal pointer; otherwise lowest index wins.
import kgp_wb_pkg::*;

module wb_rr_arbiter #(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
`ifdef ARB_ROUND_ROBIN_EN
   input  logic               clk,
`endif
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      int unsigned idx;
      logic        found;
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = (32'(ptr_q) + off) % NUM_REQ;
         if (!found && req[idx] && !rst) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
            ptr_d    = PTR_W'((idx + 1) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && !rst) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with a destination scoreboard; writes appear one cycle after grant.
// Arbitration policy chosen by ARB_ROUND_ROBIN_EN (see wb_rr_arbiter).
import kgp_wb_pkg::*;

module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rf_wren,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   input  logic                      sb_set_valid,
   input  logic [ADDR_W-1:0]         sb_set_addr,
   input  logic [ADDR_W-1:0]         chk_addr0,
   input  logic [ADDR_W-1:0]         chk_addr1,
   output logic                      chk_busy0,
   output logic                      chk_busy1,
   output logic [2**ADDR_W-1:0]      sb_busy
);

   logic [NUM_REQ-1:0]   gnt;
   logic                 gnt_any;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;

   logic                 rf_wren_q,  rf_wren_d;
   logic [ADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
   logic [2**ADDR_W-1:0] sb_busy_q,  sb_busy_d;

   wb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
`ifdef ARB_ROUND_ROBIN_EN
      .clk     (clk),
`endif
      .rst     (rst),
      .req     (req_valid),
      .gnt     (gnt)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign gnt_any   = |gnt;
   assign req_ready = gnt;

   always_comb begin
      rf_wren_d  = gnt_any;
      rf_waddr_d = gnt_any ? sel_addr : rf_waddr_q;
      rf_wdata_d = gnt_any ? sel_data : rf_wdata_q;
   end

   // Set is applied after clear so a same-address collision leaves the bit busy.
   always_comb begin
      sb_busy_d = sb_busy_q;
      if (rf_wren_q)    sb_busy_d[rf_waddr_q]  = 1'b0;
      if (sb_set_valid) sb_busy_d[sb_set_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wren_q  <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         sb_busy_q  <= '0;
      end else begin
         rf_wren_q  <= rf_wren_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         sb_busy_q  <= sb_busy_d;
      end
   end

   assign rf_wren   = rf_wren_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign sb_busy   = sb_busy_q;

   // A granted write still in flight counts as pending for operand checks.
   assign chk_busy0 = sb_busy_q[chk_addr0] | (gnt_any && (sel_addr == chk_addr0));
   assign chk_busy1 = sb_busy_q[chk_addr1] | (gnt_any && (sel_addr == chk_addr1));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             rf_wren;
   logic [AW-1:0]    rf_waddr;
   logic [DW-1:0]    rf_wdata;
   logic             sb_set_valid;
   logic [AW-1:0]    sb_set_addr;
   logic [AW-1:0]    chk_addr0;
   logic [AW-1:0]    chk_addr1;
   logic             chk_busy0;
   logic             chk_busy1;
   logic [2**AW-1:0] sb_busy;

   int n_checks = 0;
   int n_fails  = 0;

   regfile_wb_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rf_wren      (rf_wren),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .sb_set_valid (sb_set_valid),
      .sb_set_addr  (sb_set_addr),
      .chk_addr0    (chk_addr0),
      .chk_addr1    (chk_addr1),
      .chk_busy0    (chk_busy0),
      .chk_busy1    (chk_busy1),
      .sb_busy      (sb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      int unsigned ei;
      logic [NR-1:0] exp_gnt;
      logic          rr;
`ifdef ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      rst          = 1'b1;
      req_valid    = 3'b111;
      req_addr     = '0;
      req_data     = '0;
      sb_set_valid = 1'b0;
      sb_set_addr  = '0;
      chk_addr0    = '0;
      chk_addr1    = '0;

      // Reset state, with requests already present
      #2;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_wren",  64'(rf_wren),   64'h0);
      check("rst_waddr", 64'(rf_waddr),  64'h0);
      check("rst_wdata", 64'(rf_wdata),  64'h0);
      check("rst_busy",  64'(sb_busy),   64'h0);
      tick();
      check("rst_wren_edge", 64'(rf_wren), 64'h0);
      rst = 1'b0;
      set_req(0, 5'd1, 32'h100);
      set_req(1, 5'd2, 32'h200);
      set_req(2, 5'd3, 32'h300);

      // Arbitration order with all three requesting
      for (int unsigned c = 0; c < 6; c++) begin
         ei      = rr ? (c % 3) : 0;
         exp_gnt = 3'(1 << ei);
         #1;
         check($sformatf("arb_ready_%0d", c), 64'(req_ready), 64'(exp_gnt));
         tick();
         check($sformatf("arb_wren_%0d", c),  64'(rf_wren),  64'h1);
         check($sformatf("arb_waddr_%0d", c), 64'(rf_waddr), 64'(ei + 1));
         check($sformatf("arb_wdata_%0d", c), 64'(rf_wdata), 64'((ei + 1) << 8));
      end
      req_valid = '0;
      #1;
      check("idle_ready", 64'(req_ready), 64'h0);
      tick();
      check("idle_wren",  64'(rf_wren),  64'h0);
      check("idle_waddr", 64'(rf_waddr), rr ? 64'd3 : 64'd1);

      // Single request
      set_req(0, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b001;
      chk_addr0 = 5'd5;
      chk_addr1 = 5'd0;
      #1;
      check("single_ready", 64'(req_ready), 64'h1);
      check("single_pend0", 64'(chk_busy0), 64'h1);
      check("single_pend1", 64'(chk_busy1), 64'h0);
      tick();
      req_valid = '0;
      check("single_wren",  64'(rf_wren),  64'h1);
      check("single_waddr", 64'(rf_waddr), 64'h5);
      check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
      tick();
      check("hold_wren",  64'(rf_wren),  64'h0);
      check("hold_waddr", 64'(rf_waddr), 64'h5);
      check("hold_wdata", 64'(rf_wdata), 64'hDEADBEEF);

      // Write to address 0 passes through
      set_req(2, 5'd0, 32'h55AA);
      req_valid = 3'b100;
      #1;
      check("a0_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      check("a0_wren",  64'(rf_wren),  64'h1);
      check("a0_waddr", 64'(rf_waddr), 64'h0);
      check("a0_wdata", 64'(rf_wdata), 64'h55AA);

      // Asynchronous reset mid-cycle with busy bits and a pending request
      set_req(1, 5'd4, 32'h44);
      req_valid    = 3'b010;
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd3;
      #1;
      check("pre_rst_ready", 64'(req_ready), 64'h2);
      tick();
      sb_set_valid = 1'b0;
      check("pre_rst_wren", 64'(rf_wren), 64'h1);
      check("pre_rst_busy", 64'(sb_busy), 64'h8);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  64'(sb_busy),   64'h0);
      check("arst_wren",  64'(rf_wren),   64'h0);
      check("arst_waddr", 64'(rf_waddr),  64'h0);
      check("arst_ready", 64'(req_ready), 64'h0);
      #1;
      rst = 1'b0;

      // Same-address conflict straight after reset
      set_req(0, 5'd7, 32'h1);
      set_req(1, 5'd7, 32'h2);
      req_valid = 3'b011;
      chk_addr1 = 5'd7;
      #1;
      check("conf_ready0", 64'(req_ready), 64'h1);
      check("conf_pend",   64'(chk_busy1), 64'h1);
      tick();
      req_valid = 3'b010;
      check("conf_waddr0", 64'(rf_waddr), 64'h7);
      check("conf_wdata0", 64'(rf_wdata), 64'h1);
      #1;
      check("conf_ready1", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      check("conf_wren1",  64'(rf_wren),  64'h1);
      check("conf_waddr1", 64'(rf_waddr), 64'h7);
      check("conf_wdata1", 64'(rf_wdata), 64'h2);

      // Scoreboard set, pending check, clear after the write
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd9;
      tick();
      sb_set_valid = 1'b0;
      chk_addr0    = 5'd9;
      chk_addr1    = 5'd10;
      #1;
      check("sb_set_vec", 64'(sb_busy),   64'h200);
      check("sb_busy0",   64'(chk_busy0), 64'h1);
      check("sb_busy1",   64'(chk_busy1), 64'h0);
      set_req(2, 5'd9, 32'h99);
      req_valid = 3'b100;
      #1;
      check("sb_pend_gnt", 64'(chk_busy0), 64'h1);
      tick();
      req_valid = '0;
      check("sb_wr_waddr", 64'(rf_waddr), 64'h9);
      check("sb_wr_busy0", 64'(chk_busy0), 64'h1);
      tick();
      check("sb_clr_busy0", 64'(chk_busy0), 64'h0);
      check("sb_clr_vec",   64'(sb_busy),   64'h0);

      // Set and clear of the same address in one cycle: set wins
      set_req(2, 5'd9, 32'h9A);
      req_valid = 3'b100;
      tick();
      req_valid    = '0;
      sb_set_valid = 1'b1;
      sb_set_addr  = 5'd9;
      check("col_wren", 64'(rf_wren), 64'h1);
      tick();
      sb_set_valid = 1'b0;
      check("col_vec",   64'(sb_busy),   64'h200);
      check("col_busy0", 64'(chk_busy0), 64'h1);
      tick();
      check("col_hold", 64'(sb_busy), 64'h200);

      // Re-setting a busy bit does not count; one write clears it
      sb_set_valid = 1'b1;
      tick();
      sb_set_valid = 1'b0;
      check("reset_busy_vec", 64'(sb_busy), 64'h200);
      set_req(2, 5'd9, 32'h9B);
      req_valid = 3'b100;
      tick();
      req_valid = '0;
      tick();
      check("nocount_vec",   64'(sb_busy),   64'h0);
      check("nocount_busy0", 64'(chk_busy0), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write-back requesters.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester write request.
REQ-007 SHALL have port req_addr, input, NUM_REQ*ADDR_W, per-requester destination; requester i uses slice i.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_W, per-requester write data; requester i uses slice i.
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot grant; combinational.
REQ-010 SHALL have port rf_wren, output, 1, register-file write enable; registered.
REQ-011 SHALL have port rf_waddr, output, ADDR_W, register-file write address; registered.
REQ-012 SHALL have port rf_wdata, output, DATA_W, register-file write data; registered.
REQ-013 SHALL have port sb_set_valid, input, 1, reserve a destination at issue.
REQ-014 SHALL have port sb_set_addr, input, ADDR_W, destination to reserve.
REQ-015 SHALL have ports chk_addr0 and chk_addr1, input, ADDR_W each, source operands to check.
REQ-016 SHALL have ports chk_busy0 and chk_busy1, output, 1 each, source pending write; combinational.
REQ-017 SHALL have port sb_busy, output, 2**ADDR_W, scoreboard bit vector; registered.

Function
REQ-018 SHALL grant at most one requester per cycle, and only a requester with req_valid=1.
REQ-019 SHALL transfer on req_valid[i]&req_ready[i]; the requester holds addr/data stable until granted.
REQ-020 SHALL drive rf_wren=1, rf_waddr, rf_wdata of the granted request on the cycle after the grant; latency is exactly 1.
REQ-021 SHALL drive rf_wren=0 in any cycle following a cycle with no grant; rf_waddr and rf_wdata hold their last values.
REQ-022 SHALL set sb_busy[sb_set_addr] on the clock edge where sb_set_valid=1.
REQ-023 SHALL clear sb_busy[rf_waddr] on the clock edge where rf_wren=1.
REQ-024 SHALL give set priority when a set and a clear hit the same address in the same cycle, leaving the bit at 1.
REQ-025 SHALL leave a bit at 1 when setting an already-busy address; there is no counting.
REQ-026 SHALL drive chk_busyN = sb_busy[chk_addrN] | (grant pending to chk_addrN this cycle), with no bypass of data.
REQ-027 SHALL serialise two requesters targeting the same address in one cycle in arbitration order, so the later grant's data is the final value.
REQ-028 SHALL accept write requests to address 0 and pass them through unmodified.

Reset
REQ-029 SHALL, while rst=1 and independent of clk, set rf_wren=0, rf_waddr=0, rf_wdata=0, sb_busy=0 and the arbitration pointer=0.
REQ-030 SHALL drive req_ready=0 while rst=1.
REQ-031 SHALL lose a grant issued in the cycle rst asserts; no write is emitted for it.

Configuration
REQ-032 SHALL, with ARB_ROUND_ROBIN_EN defined, use round-robin arbitration: search starts at the pointer, wraps modulo NUM_REQ, and the pointer becomes grant index+1 (mod NUM_REQ) after each grant.
REQ-033 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority with the lowest index winning, and SHALL not implement the pointer.

Structure
REQ-034 SHALL place NUM_REQ, ADDR_W and DATA_W defaults plus requester index constants REQ_ALU=0, REQ_MEM=1 and REQ_LINK=2 in the shared package kgp_wb_pkg.
REQ-035 SHALL implement arbitration in the sub-module wb_rr_arbiter (req vector in, one-hot grant out, pointer inside); the scoreboard and output register stay in the top module.

Verification
REQ-036 SHALL cover single request: req_valid=001, addr0=5, data0=0xDEADBEEF -> req_ready=001, next cycle rf_wren=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-037 SHALL cover round-robin (macro on): req_valid=111 held 6 cycles -> grants 001,010,100,001,010,100; macro off -> 001 on all six cycles.
REQ-038 SHALL cover same-address conflict: req0 addr7=0x1 and req1 addr7=0x2 in one cycle, from reset -> rf_waddr=7 writes 0x1 then 0x2 on consecutive cycles.
REQ-039 SHALL cover scoreboard: sb_set 9, then chk_addr0=9 -> chk_busy0=1 until the cycle after the write to 9; a simultaneous set 9 with rf_wren on 9 -> sb_busy[9] stays 1.
REQ-040 SHALL cover asynchronous reset: rst pulsed mid-cycle with busy bits set and a request pending -> sb_busy=0, rf_wren=0 immediately, and the first grant after release goes to requester 0.
